// File: rtl/tl_pkg.sv
// -----------------------------------------------------------------------------
// tl_pkg
// Shared definitions for the intersection phase scheduler, the lamp driver and
// the bench: lamp encodings and the ten phase state codes. The numeric state
// code is exported on the scheduler's debug 'phase' port.
// -----------------------------------------------------------------------------
package tl_pkg;

    // Lamp drive encoding, one 2-bit field per road.
    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10,
        LEFT   = 2'b11
    } lamp_t;

    // Phase states. A-side phases first, B-side phases mirror them.
    typedef enum logic [3:0] {
        A_GO   = 4'd0,
        A_Y    = 4'd1,
        A_LEFT = 4'd2,
        A_LY   = 4'd3,
        A_AR   = 4'd4,
        B_GO   = 4'd5,
        B_Y    = 4'd6,
        B_LEFT = 4'd7,
        B_LY   = 4'd8,
        B_AR   = 4'd9
    } state_t;

    // Width of the in-state dwell counter.
    localparam int DWELL_W = 8;

endpackage

// File: rtl/tl_dwell_cntr.sv
// -----------------------------------------------------------------------------
// tl_dwell_cntr
// Counts cycles spent in the current phase. Saturates at all-ones so a green
// held indefinitely never wraps back below the minimum-green threshold.
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset (count -> 0)
//   clr      in   synchronous clear, asserted on the cycle a phase change is taken
//   count    out  8-bit dwell count, 0 on the first cycle of a phase
// -----------------------------------------------------------------------------
module tl_dwell_cntr
    import tl_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    output logic [DWELL_W-1:0] count
);

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples its inputs before any of them update at the clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (count != {DWELL_W{1'b1}}) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/tl_phase_scheduler.sv
// -----------------------------------------------------------------------------
// tl_phase_scheduler
// Timed phase sequencer for a two-road intersection with protected left turns.
// Through greens honour a minimum dwell and, while the own road still has
// traffic, a maximum dwell. Left-turn requests are latched so short pulses
// are served on the next pass through the road's yellow.
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset (-> A_GO, latches cleared)
//   Ta, Tb   in   through traffic present on road A / road B
//   Tal, Tbl in   left-turn request on road A / road B
//   La, Lb   out  lamp codes (tl_pkg::lamp_t), Moore decode of the state
//   phase    out  current state code (debug)
// -----------------------------------------------------------------------------
module tl_phase_scheduler
    import tl_pkg::*;
#(
    parameter int unsigned T_MIN_GREEN = 4,
    parameter int unsigned T_MAX_GREEN = 12,
    parameter int unsigned T_YELLOW    = 2,
    parameter int unsigned T_LEFT      = 3,
    parameter int unsigned T_ALLRED    = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       Ta,
    input  logic       Tal,
    input  logic       Tb,
    input  logic       Tbl,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic [3:0] phase
);

    // Dwell is 0 on the first cycle of a phase, so an N-cycle phase exits
    // when the count reaches N-1.
    localparam logic [DWELL_W-1:0] MIN_G_END = DWELL_W'(T_MIN_GREEN - 1);
    localparam logic [DWELL_W-1:0] MAX_G_END = DWELL_W'(T_MAX_GREEN - 1);
    localparam logic [DWELL_W-1:0] YEL_END   = DWELL_W'(T_YELLOW - 1);
    localparam logic [DWELL_W-1:0] LEFT_END  = DWELL_W'(T_LEFT - 1);
    localparam logic [DWELL_W-1:0] AR_END    = DWELL_W'(T_ALLRED - 1);

    state_t             state;
    state_t             next_state;
    logic [DWELL_W-1:0] dwell;
    logic               dwell_clr;
    logic               left_a;
    logic               left_b;
    logic               demand_a;
    logic               demand_b;

    // A pending left on either road counts as demand for both roads: the
    // holder of green must yield so the requesting road comes round to its
    // yellow, where the left is served.
    assign demand_a  = Ta | Tal | left_a | left_b;
    assign demand_b  = Tb | Tbl | left_b | left_a;
    assign dwell_clr = (next_state != state);

    tl_dwell_cntr u_dwell (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (dwell_clr),
        .count   (dwell)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= A_GO;
        end else begin
            state <= next_state;
        end
    end

    // Left-turn request latches. Requests during the road's own left or
    // left-yellow are dropped; entry to the left phase consumes the request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            left_a <= 1'b0;
            left_b <= 1'b0;
        end else begin
            if (next_state == A_LEFT && state != A_LEFT) begin
                left_a <= 1'b0;
            end else if (Tal && state != A_LEFT && state != A_LY) begin
                left_a <= 1'b1;
            end

            if (next_state == B_LEFT && state != B_LEFT) begin
                left_b <= 1'b0;
            end else if (Tbl && state != B_LEFT && state != B_LY) begin
                left_b <= 1'b1;
            end
        end
    end

    // Next-state logic.
    // NOTE: next_state gets a default before the case so every path assigns
    // it and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            A_GO: begin
                if (dwell >= MIN_G_END && demand_b && (!Ta || dwell >= MAX_G_END))
                    next_state = A_Y;
            end
            A_Y: begin
                if (dwell == YEL_END)
                    next_state = left_a ? A_LEFT : A_AR;
            end
            A_LEFT: begin
                if (dwell == LEFT_END) next_state = A_LY;
            end
            A_LY: begin
                if (dwell == YEL_END) next_state = A_AR;
            end
            A_AR: begin
                if (dwell == AR_END) next_state = B_GO;
            end
            B_GO: begin
                if (dwell >= MIN_G_END && demand_a && (!Tb || dwell >= MAX_G_END))
                    next_state = B_Y;
            end
            B_Y: begin
                if (dwell == YEL_END)
                    next_state = left_b ? B_LEFT : B_AR;
            end
            B_LEFT: begin
                if (dwell == LEFT_END) next_state = B_LY;
            end
            B_LY: begin
                if (dwell == YEL_END) next_state = B_AR;
            end
            B_AR: begin
                if (dwell == AR_END) next_state = A_GO;
            end
            default: next_state = A_GO;
        endcase
    end

    // Lamp decode: the road not named by the state is always RED.
    always_comb begin
        La = RED;
        Lb = RED;
        case (state)
            A_GO:        La = GREEN;
            A_Y, A_LY:   La = YELLOW;
            A_LEFT:      La = LEFT;
            B_GO:        Lb = GREEN;
            B_Y, B_LY:   Lb = YELLOW;
            B_LEFT:      Lb = LEFT;
            default: ;
        endcase
    end

    assign phase = state;

endmodule

// File: doc/tl_phase_scheduler.md
# tl_phase_scheduler

Timed phase scheduler for a two-road intersection with protected left turns on both roads. Consumes the four traffic sensors (through A, left A, through B, left B) and sequences La/Lb through green, yellow, protected-left and all-red clearance phases. Enforces minimum and maximum green dwell and serves latched left-turn requests. Sits between the sensor inputs and the lamp drivers, replacing the untimed per-cycle controller.

## Interface
- T_MIN_GREEN, 4: minimum cycles in a through-green phase (1..255)
- T_MAX_GREEN, 12: maximum green cycles while competing demand exists (T_MIN_GREEN..255)
- T_YELLOW, 2: cycles in each yellow phase (1..255)
- T_LEFT, 3: cycles in each protected-left phase (1..255)
- T_ALLRED, 1: cycles of all-red clearance (1..255)

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- Ta  in  1  through traffic waiting/present on road A
- Tal  in  1  left-turn request on road A
- Tb  in  1  through traffic on road B
- Tbl  in  1  left-turn request on road B
- La  out  2  road A lamp: 00 GREEN, 01 YELLOW, 10 RED, 11 LEFT-ARROW
- Lb  out  2  road B lamp, same encoding
- phase  out  4  current state code (debug)

## Operation
- Ten states: A_GO, A_Y, A_LEFT, A_LY, A_AR, B_GO, B_Y, B_LEFT, B_LY, B_AR. Lamps are a Moore decode of state; the road not named is RED; all-red states drive both RED.
- A_GO: La=GREEN. A_Y and A_LY: La=YELLOW. A_LEFT: La=LEFT. B side symmetric.
- Dwell counter: 8-bit, cleared on every state change, increments each cycle in-state, saturates at 255.
- Left latches left_a/left_b: set when Tal/Tbl is high in any state except X_LEFT or X_LY of the same road; cleared on entry to X_LEFT.
- A_GO exit to A_Y when dwell >= T_MIN_GREEN-1 and demand_b (Tb | Tbl | left_b | left_a) holds, and either Ta=0 or dwell >= T_MAX_GREEN-1. No demand: hold green indefinitely.
- A_Y exit when dwell == T_YELLOW-1: to A_LEFT if left_a, else A_AR.
- A_LEFT to A_LY after T_LEFT cycles; A_LY to A_AR after T_YELLOW; A_AR to B_GO after T_ALLRED.
- B side mirrors: B_AR goes to A_GO; demand_a = Ta | Tal | left_a | left_b.
- Simultaneous pending left and opposite through: own left served first, then the opposite road.
- After a protected left, the scheduler always proceeds to the opposite road's green, even without demand there.

## Timing
- Reset (asynchronous, immediate): state A_GO, dwell 0, latches 0, La=00, Lb=10, phase=0.
- Sensors sampled at each rising edge. Lamp outputs change one cycle after the edge that satisfies an exit condition; they are decoded from registered state.
- Timed state of length N lasts exactly N cycles.
- Green with exit condition already true at entry lasts exactly T_MIN_GREEN cycles.
- No two roads are ever non-RED in the same cycle.
- A one-cycle Tal pulse is never lost unless it arrives during A_LEFT or A_LY.

## Structure
- Shared package tl_pkg: lamp encodings (GREEN, YELLOW, RED, LEFT) and state codes, shared with the lamp driver and bench.
- Sub-module tl_dwell_cntr: 8-bit saturating up-counter with synchronous clear input and async reset.
- Top module holds the state register, left latches, next-state logic and lamp decode.

## Test plan
- Reset, all sensors 0 for 30 cycles -> La=GREEN, Lb=RED throughout.
- Ta=0, Tb=1 from reset release -> A_GO for 4 cycles, La=YELLOW for 2, both RED for 1, Lb=GREEN at cycle 7.
- Ta=1, Tb=1 constant -> A green 12, yellow 2, all-red 1, B green 12, repeating; never both non-RED.
- One-cycle Tal pulse at cycle 1, other sensors 0 -> A green 4, yellow 2, LEFT 3, yellow 2, all-red 1, then B_GO held.
- Tal and Tb both high at A_Y -> A_LEFT served before B_GO.
- reset_n low mid A_LEFT -> La=GREEN, Lb=RED before the next edge; left_a cleared; normal sequencing resumes after release.
